// File: rtl/stream_ingress_if.sv
// Word stream bundle: valid/ready handshake with 64-bit data and last marker.
// The master drives valid, data and last; the slave returns ready.
interface stream_ingress_if;
    logic        valid;
    logic        ready;
    logic        last;
    logic [63:0] data;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/stream_ingress.sv
// Host-to-core word gate: checks transfer length against mode/security level,
// forwards legal words with zero latency and swallows the rest.
module stream_ingress #(
    parameter int CNT_W  = 16,
    parameter int MIN_V2 = 164,
    parameter int MIN_V3 = 244,
    parameter int MIN_V5 = 324,
    parameter int MIN_S2 = 316,
    parameter int MIN_S3 = 500,
    parameter int MIN_S5 = 608
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [2:0]       sec_lvl,
    stream_ingress_if.slave  host,
    stream_ingress_if.master core,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       lvl_q, lvl_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      cnt_ext;
    logic [31:0]      min_len;
    logic             cfg_bad;
    logic             lvl_ok;

    assign lvl_ok  = (sec_lvl == 3'd2) || (sec_lvl == 3'd3) ||
                     (sec_lvl == 3'd5);
    assign cfg_bad = (mode == 2'd3) || !lvl_ok;

    // Saturating increment: the counter sticks at all-ones.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign cnt_ext = 32'(cnt_inc);

    always_comb begin
        min_len = 32'd4;
        if (mode_q == 2'd1) begin
            case (lvl_q)
                3'd2:    min_len = 32'(MIN_V2);
                3'd3:    min_len = 32'(MIN_V3);
                default: min_len = 32'(MIN_V5);
            endcase
        end else if (mode_q == 2'd2) begin
            case (lvl_q)
                3'd2:    min_len = 32'(MIN_S2);
                3'd3:    min_len = 32'(MIN_S3);
                default: min_len = 32'(MIN_S5);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            lvl_q   <= 3'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lvl_q   <= lvl_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lvl_d      = lvl_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        core.valid = 1'b0;
        host.ready = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    lvl_d   = sec_lvl;
                    cnt_d   = '0;
                    err_d   = cfg_bad;
                    state_d = cfg_bad ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                core.valid = host.valid;
                host.ready = core.ready;
                if (host.valid && core.ready) begin
                    cnt_d = cnt_inc;
                    if (host.last) begin
                        err_d   = (cnt_ext < min_len);
                        state_d = DONE;
                    end else if (mode_q == 2'd0 &&
                                 cnt_ext == 32'd4) begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                host.ready = 1'b1;
                if (host.valid && host.last)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign core.data = host.data;
    assign core.last = host.last;
    assign err       = err_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_stream_ingress.sv
// Directed bench for stream_ingress: length checks, draining,
// handshake gating and reset abort.
module tb_stream_ingress;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  sec_lvl;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fwd;
    int          drn;

    stream_ingress_if host_if();
    stream_ingress_if core_if();

    stream_ingress dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .sec_lvl  (sec_lvl),
        .host     (host_if),
        .core     (core_if),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int k);
        return 64'hC0DE_0000_0000_0000 ^ (64'(k) * 64'h9E37_79B9);
    endfunction

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [1:0] m, input logic [2:0] l);
        start   = 1'b1;
        mode    = m;
        sec_lvl = l;
        tick();
        start   = 1'b0;
    endtask

    // Offer n host words (last on index last_at); count forwarded and
    // swallowed words; every forwarded word must match the host order.
    task automatic xfer(input int n, input int last_at, input bit tog,
                        output int f, output int d);
        int idx = 0;
        int cyc = 0;
        f = 0;
        d = 0;
        while (idx < n && cyc < 3000) begin
            host_if.valid = 1'b1;
            host_if.data  = pat(idx);
            host_if.last  = (idx == last_at);
            core_if.ready = tog ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (core_if.valid && core_if.ready) begin
                if (core_if.data !== pat(f))
                    check("fwd_order", core_if.data, pat(f));
                f++;
            end
            if (host_if.valid && host_if.ready) begin
                if (!(core_if.valid && core_if.ready))
                    d++;
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        host_if.valid = 1'b0;
        host_if.last  = 1'b0;
        check("xfer_budget", 64'(idx), 64'(n));
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        mode          = 2'd0;
        sec_lvl       = 3'd2;
        host_if.valid = 1'b1;
        host_if.data  = 64'h1234_5678_9ABC_DEF0;
        host_if.last  = 1'b0;
        core_if.ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cnt", 64'(word_cnt), 64'd0);
        check("idle_valid_o", 64'(core_if.valid), 64'd0);
        check("idle_ready_i", 64'(host_if.ready), 64'd0);
        check("idle_data_o", core_if.data, 64'h1234_5678_9ABC_DEF0);
        host_if.valid = 1'b0;
        tick();

        // keygen, exact length
        kick(2'd0, 3'd2);
        xfer(4, 3, 1'b0, fwd, drn);
        check("kg_fwd", 64'(fwd), 64'd4);
        check("kg_done", 64'(done), 64'd1);
        check("kg_err", 64'(err), 64'd0);
        check("kg_cnt", 64'(word_cnt), 64'd4);
        tick();
        check("kg_done_pulse", 64'(done), 64'd0);
        host_if.valid = 1'b1;
        #1;
        check("kg_idle_ready", 64'(host_if.ready), 64'd0);
        check("kg_idle_cnt", 64'(word_cnt), 64'd4);
        host_if.valid = 1'b0;

        // verify L3, ready toggling
        kick(2'd1, 3'd3);
        check("v3_cnt_clr", 64'(word_cnt), 64'd0);
        xfer(244, 243, 1'b1, fwd, drn);
        check("v3_fwd", 64'(fwd), 64'd244);
        check("v3_done", 64'(done), 64'd1);
        check("v3_err", 64'(err), 64'd0);
        check("v3_cnt", 64'(word_cnt), 64'd244);
        tick();

        // sign L5, short
        kick(2'd2, 3'd5);
        xfer(100, 99, 1'b0, fwd, drn);
        check("s5_fwd", 64'(fwd), 64'd100);
        check("s5_done", 64'(done), 64'd1);
        check("s5_err", 64'(err), 64'd1);
        check("s5_cnt", 64'(word_cnt), 64'd100);
        tick();

        // keygen, too long
        kick(2'd0, 3'd3);
        check("kl_err_clr", 64'(err), 64'd0);
        xfer(6, 5, 1'b0, fwd, drn);
        check("kl_fwd", 64'(fwd), 64'd4);
        check("kl_drain", 64'(drn), 64'd2);
        check("kl_done", 64'(done), 64'd1);
        check("kl_err", 64'(err), 64'd1);
        check("kl_cnt", 64'(word_cnt), 64'd4);
        tick();

        // illegal mode
        kick(2'd3, 3'd2);
        check("im_err_early", 64'(err), 64'd1);
        xfer(5, 4, 1'b0, fwd, drn);
        check("im_fwd", 64'(fwd), 64'd0);
        check("im_drain", 64'(drn), 64'd5);
        check("im_done", 64'(done), 64'd1);
        check("im_cnt", 64'(word_cnt), 64'd0);
        tick();

        // illegal level
        kick(2'd1, 3'd4);
        xfer(3, 2, 1'b0, fwd, drn);
        check("il_fwd", 64'(fwd), 64'd0);
        check("il_done", 64'(done), 64'd1);
        check("il_err", 64'(err), 64'd1);
        tick();

        // verify L2 at MIN-1 and MIN
        kick(2'd1, 3'd2);
        xfer(163, 162, 1'b0, fwd, drn);
        check("v2_short_err", 64'(err), 64'd1);
        check("v2_short_cnt", 64'(word_cnt), 64'd163);
        tick();
        kick(2'd1, 3'd2);
        xfer(164, 163, 1'b0, fwd, drn);
        check("v2_min_err", 64'(err), 64'd0);
        check("v2_min_done", 64'(done), 64'd1);
        tick();

        // reset mid-stream; start held with bad mode must be ignored
        kick(2'd1, 3'd3);
        start = 1'b1;
        mode  = 2'd3;
        xfer(50, -1, 1'b0, fwd, drn);
        check("ab_pre_cnt", 64'(word_cnt), 64'd50);
        check("ab_pre_err", 64'(err), 64'd0);
        start         = 1'b0;
        rst           = 1'b1;
        host_if.valid = 1'b1;
        core_if.ready = 1'b1;
        tick();
        check("ab_valid_o", 64'(core_if.valid), 64'd0);
        check("ab_ready_i", 64'(host_if.ready), 64'd0);
        check("ab_cnt", 64'(word_cnt), 64'd0);
        check("ab_err", 64'(err), 64'd0);
        check("ab_done", 64'(done), 64'd0);
        rst           = 1'b0;
        host_if.valid = 1'b0;
        tick();
        check("ab_no_done", 64'(done), 64'd0);

        kick(2'd0, 3'd5);
        xfer(4, 3, 1'b0, fwd, drn);
        check("rs_fwd", 64'(fwd), 64'd4);
        check("rs_done", 64'(done), 64'd1);
        check("rs_err", 64'(err), 64'd0);
        check("rs_cnt", 64'(word_cnt), 64'd4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
